cellrv32_cpu_cp_fpu32_i2f: RTL and testbench
============================================

Name: cellrv32_cpu_cp_fpu32_i2f

Overview:
Multi-cycle integer-to-single-precision-float converter for the FPU co-processor. It implements FCVT.S.W and FCVT.S.WU.
It takes a 32-bit signed or unsigned integer and produces an IEEE-754 binary32 result with rounding and exception flags.
It sits beside the float-to-int converter inside the FPU and uses the same start/done handshake. Normalization is a bit-serial left shift, one bit per cycle.

Parameters:
XLEN, 32, integer data path width; only 32 is supported.

Ports:
clk_i  in  1  global clock, rising edge
rst_i  in  1  global reset, asynchronous, active-high
start_i  in  1  trigger conversion; sampled only in S_IDLE
rmode_i  in  3  rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM)
funct_i  in  1  0=signed source, 1=unsigned source
rs1_i  in  32  integer operand
result_o  out  32  float result; registered, holds until next completion
flags_o  out  5  exception flags, indexed by package fp_exc_*_c constants
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_i=1): state=S_IDLE; result_o=0, flags_o=0, done_o=0; all internal registers cleared.
- Reset mid-operation: abort immediately, no done_o pulse, outputs are 0.
- S_IDLE:
  - On start_i=1, capture rs1_i, funct_i and rmode_i, then go to S_PREPARE.
  - start_i in any other state is ignored; no queuing.
- S_PREPARE:
  - sign = ~funct_i & rs1[31].
  - mag = sign ? (0 - rs1) : rs1, taken modulo 2^32, so 0x80000000 gives mag 0x80000000.
  - exp = 158 (127+31), 8 bits.
  - If mag==0, go to S_FINALIZE with a zero flag set; otherwise go to S_NORMALIZE.
- S_NORMALIZE:
  - If mag[31]=0: mag <= mag<<1, exp <= exp-1, stay in S_NORMALIZE.
  - If mag[31]=1: go to S_ROUND.
  - This state occupies n+1 cycles, where n = leading-zero count of mag (0..31).
- S_ROUND:
  - Field split: mant = mag[30:8], guard g = mag[7], round r = mag[6], sticky s = |mag[5:0].
  - inexact = g|r|s.
  - Round-up enable inc, by mode:
    - RNE: g & (r|s|mant[0])
    - RTZ: 0
    - RDN: sign & inexact
    - RUP: ~sign & inexact
    - RMM: g
    - 101/110/111: 0
  - {carry, mant} = mant + inc, 24 bits.
  - If carry=1: mant = 0, exp = exp+1. Maximum exp is 159, so no overflow is possible.
  - Go to S_FINALIZE.
- S_FINALIZE:
  - result_o = zero ? 0x00000000 : {sign, exp, mant}.
  - flags_o[fp_exc_nx_c] = inexact; all other flags are 0 (NV, DZ, OF and UF are impossible).
  - done_o=1 for exactly this one registered cycle; return to S_IDLE.
  - Zero input always gives +0.0 with flags 0.
- Latency, counting from the start_i sampling edge k:
  - non-zero input: done_o goes high after edge k+n+4;
  - zero input: done_o goes high after edge k+2;
  - a new start_i is accepted in the cycle done_o is high (FSM is in S_IDLE).
- result_o and flags_o update only at the S_FINALIZE edge. They are stable between completions.

Decomposition:
- Shared package (cellrv32_package) holds:
  - fp_exc_nv_c/dz_c/of_c/uf_c/nx_c flag indices;
  - rounding-mode encodings;
  - the float bias constant (127).
- The state enum and ctrl/sreg structs stay local to the module.
- An optional sub-module, cellrv32_cpu_cp_fpu32_rnd_inc, is natural: combinational round-enable plus 24-bit incrementer. Everything else stays in one module.

Test Plan:
- Signed 0x00000001, RNE -> 0x3F800000, flags 0, done_o 35 cycles after start (n=31).
- Signed 0xFFFFFFFF -> 0xBF800000, flags 0. Signed 0x80000000 -> 0xCF000000, done_o 4 cycles after start (n=0).
- Unsigned 0xFFFFFFFF: RNE -> 0x4F800000 with NX (mantissa carry, exp 159); RTZ -> 0x4F7FFFFF with NX.
- Signed 0x01000001: RNE -> 0x4B800000 with NX (tie, even); RUP -> 0x4B800001 with NX. 0x01000003 RNE -> 0x4B800002 with NX. Signed -16777217 with RDN -> 0xCB800001 with NX.
- 0x00000000 (signed and unsigned) -> 0x00000000, flags 0, done_o 2 cycles after start. start_i pulses while busy are ignored: exactly one done_o per accepted start.
- Assert rst_i during S_NORMALIZE -> no done_o, result_o=0, flags_o=0. A subsequent start of 0x00000064 -> 0x42C80000.

Source files
------------

// File: rtl/cellrv32_package.sv
// Shared FPU definitions: exception flag indices, rounding-mode encodings
// and the single-precision exponent bias.
package cellrv32_package;

    localparam int fp_exc_nv_c = 4;
    localparam int fp_exc_dz_c = 3;
    localparam int fp_exc_of_c = 2;
    localparam int fp_exc_uf_c = 1;
    localparam int fp_exc_nx_c = 0;

    localparam logic [2:0] rm_rne_c = 3'b000;
    localparam logic [2:0] rm_rtz_c = 3'b001;
    localparam logic [2:0] rm_rdn_c = 3'b010;
    localparam logic [2:0] rm_rup_c = 3'b011;
    localparam logic [2:0] rm_rmm_c = 3'b100;

    localparam int fp_bias_c = 127;

endpackage

// File: rtl/cellrv32_cpu_cp_fpu32_i2f_if.sv
// Start/done handshake and operand/result bus of the int-to-float converter.
interface cellrv32_cpu_cp_fpu32_i2f_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      rmode_i;
    logic            funct_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] result_o;
    logic [4:0]      flags_o;
    logic            done_o;

    modport master (
        output start_i, rmode_i, funct_i, rs1_i,
        input  result_o, flags_o, done_o
    );

    modport slave (
        input  start_i, rmode_i, funct_i, rs1_i,
        output result_o, flags_o, done_o
    );
endinterface

// File: rtl/cellrv32_cpu_cp_fpu32_rnd_inc.sv
// Round-up decision and 24-bit mantissa incrementer for a normalized
// magnitude whose hidden one has already been stripped off.
module cellrv32_cpu_cp_fpu32_rnd_inc
    import cellrv32_package::*;
(
    input  logic [2:0]  rmode_i,
    input  logic        sign_i,
    input  logic [30:0] frac_i,
    output logic [22:0] mant_o,
    output logic        carry_o,
    output logic        inexact_o
);
    logic [22:0] w_mant;
    logic        w_g;
    logic        w_r;
    logic        w_s;
    logic        w_inc;

    assign w_mant    = frac_i[30:8];
    assign w_g       = frac_i[7];
    assign w_r       = frac_i[6];
    assign w_s       = |frac_i[5:0];
    assign inexact_o = w_g | w_r | w_s;

    // NOTE: w_inc gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_inc = 1'b0;
        case (rmode_i)
            rm_rne_c: w_inc = w_g & (w_r | w_s | w_mant[0]);
            rm_rtz_c: w_inc = 1'b0;
            rm_rdn_c: w_inc = sign_i & inexact_o;
            rm_rup_c: w_inc = ~sign_i & inexact_o;
            rm_rmm_c: w_inc = w_g;
            default:  w_inc = 1'b0;
        endcase
    end

    // A carry out wraps the low 23 bits to zero, which is exactly the renormalized mantissa.
    assign {carry_o, mant_o} = {1'b0, w_mant} + {23'd0, w_inc};
endmodule

// File: rtl/cellrv32_cpu_cp_fpu32_i2f.sv
// FCVT.S.W / FCVT.S.WU: 32-bit integer to binary32, normalized by a
// one-bit-per-cycle left shift, then rounded per the requested mode.
module cellrv32_cpu_cp_fpu32_i2f
    import cellrv32_package::*;
#(
    parameter int XLEN = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    cellrv32_cpu_cp_fpu32_i2f_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PREPARE,
        S_NORMALIZE,
        S_ROUND,
        S_FINALIZE
    } state_t;

    typedef struct packed {
        logic       unsgn;
        logic [2:0] rmode;
        logic       sign;
        logic       zero;
        logic       nx;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] mag;
        logic [7:0]      exp;
        logic [22:0]     mant;
    } sreg_t;

    state_t          r_state;
    state_t          w_state_nxt;
    ctrl_t           r_ctrl;
    sreg_t           r_sreg;
    logic [XLEN-1:0] r_rs1;

    logic            w_sign;
    logic [XLEN-1:0] w_mag_abs;
    logic [22:0]     w_mant;
    logic            w_carry;
    logic            w_inexact;

    // Two's-complement negate wraps modulo 2^32, so 0x80000000 keeps its magnitude.
    assign w_sign    = ~r_ctrl.unsgn & r_rs1[XLEN-1];
    assign w_mag_abs = w_sign ? ('0 - r_rs1) : r_rs1;

    cellrv32_cpu_cp_fpu32_rnd_inc u_rnd_inc (
        .rmode_i   (r_ctrl.rmode),
        .sign_i    (r_ctrl.sign),
        .frac_i    (r_sreg.mag[30:0]),
        .mant_o    (w_mant),
        .carry_o   (w_carry),
        .inexact_o (w_inexact)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (bus.start_i) w_state_nxt = S_PREPARE;
            S_PREPARE:   w_state_nxt = (w_mag_abs == '0) ? S_FINALIZE : S_NORMALIZE;
            S_NORMALIZE: if (r_sreg.mag[XLEN-1]) w_state_nxt = S_ROUND;
            S_ROUND:     w_state_nxt = S_FINALIZE;
            S_FINALIZE:  w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ctrl       <= '0;
            r_sreg       <= '0;
            r_rs1        <= '0;
            bus.result_o <= '0;
            bus.flags_o  <= '0;
            bus.done_o   <= 1'b0;
        end else begin
            bus.done_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_rs1        <= bus.rs1_i;
                        r_ctrl.unsgn <= bus.funct_i;
                        r_ctrl.rmode <= bus.rmode_i;
                    end
                end
                S_PREPARE: begin
                    r_ctrl.sign <= w_sign;
                    r_ctrl.zero <= (w_mag_abs == '0);
                    r_ctrl.nx   <= 1'b0;
                    r_sreg.mag  <= w_mag_abs;
                    r_sreg.exp  <= 8'(fp_bias_c + XLEN - 1);
                    r_sreg.mant <= '0;
                end
                S_NORMALIZE: begin
                    if (!r_sreg.mag[XLEN-1]) begin
                        r_sreg.mag <= r_sreg.mag << 1;
                        r_sreg.exp <= r_sreg.exp - 8'd1;
                    end
                end
                S_ROUND: begin
                    r_sreg.mant <= w_mant;
                    r_sreg.exp  <= r_sreg.exp + {7'd0, w_carry};
                    r_ctrl.nx   <= w_inexact;
                end
                S_FINALIZE: begin
                    bus.result_o              <= r_ctrl.zero ? '0 :
                                                 {r_ctrl.sign, r_sreg.exp, r_sreg.mant};
                    bus.flags_o               <= '0;
                    bus.flags_o[fp_exc_nx_c]  <= r_ctrl.nx;
                    bus.done_o                <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cellrv32_cpu_cp_fpu32_i2f.sv
// Self-checking bench for the int-to-float converter: directed vectors,
// randomized operands against an arithmetic reference model, and control corner cases.
module tb_cellrv32_cpu_cp_fpu32_i2f;
    import cellrv32_package::*;

    localparam logic [4:0] NX = 5'd1 << fp_exc_nx_c;

    typedef struct packed {
        logic [31:0] v;
        logic        u;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cellrv32_cpu_cp_fpu32_i2f_if #(.XLEN(32)) bus ();

    cellrv32_cpu_cp_fpu32_i2f #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: exact integer magnitude, truncate to 24 significant bits, round by remainder vs half.
    task automatic ref_model(input logic [31:0] v, input logic u, input logic [2:0] rm,
                             output logic [31:0] res, output logic [4:0] fl, output int lat);
        logic [63:0] mag, q, rem, half;
        logic        sgn, inexact, up;
        int          p, sh;
        sgn = !u && v[31];
        mag = {32'd0, v};
        if (sgn) mag = 64'h1_0000_0000 - mag;
        if (mag == 0) begin
            res = 32'd0; fl = 5'd0; lat = 2;
            return;
        end
        p = 0;
        for (int i = 0; i < 33; i++) if (mag >= (64'd1 << i)) p = i;
        lat = (31 - p) + 4;
        inexact = 1'b0;
        up = 1'b0;
        if (p <= 23) begin
            q = mag << (23 - p);
        end else begin
            sh      = p - 23;
            q       = mag >> sh;
            rem     = mag - (q << sh);
            half    = 64'd1 << (sh - 1);
            inexact = (rem != 0);
            case (rm)
                3'd0: up = (rem > half) || (rem == half && q[0]);
                3'd2: up = sgn && inexact;
                3'd3: up = !sgn && inexact;
                3'd4: up = (rem >= half);
                default: up = 1'b0;
            endcase
        end
        q = q + {63'd0, up};
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            p = p + 1;
        end
        res = {sgn, 8'(p + 127), q[22:0]};
        fl  = inexact ? NX : 5'd0;
    endtask

    // Issue one start and wait (bounded) for done; lat = edges from accepting edge, -1 on timeout.
    task automatic run_conv(input logic [31:0] v, input logic u, input logic [2:0] rm,
                            output logic [31:0] res, output logic [4:0] fl, output int lat);
        lat = -1;
        res = 'x;
        fl  = 'x;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.rs1_i   = v;
        bus.funct_i = u;
        bus.rmode_i = rm;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.rs1_i   = $urandom;
        bus.funct_i = 1'($urandom);
        bus.rmode_i = 3'($urandom);
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) begin
                lat = c;
                res = bus.result_o;
                fl  = bus.flags_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.result_o !== 32'd0) begin errors++; $display("FAIL reset result: got %h want 00000000", bus.result_o); end
        checks++; if (bus.flags_o !== 5'd0) begin errors++; $display("FAIL reset flags: got %b want 00000", bus.flags_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", bus.done_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        vec_t        tbl [12];
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        tbl = '{
            '{32'h00000001, 1'b0, 3'd0, 32'h3F800000, 5'd0, 35},
            '{32'hFFFFFFFF, 1'b0, 3'd0, 32'hBF800000, 5'd0, 35},
            '{32'h80000000, 1'b0, 3'd0, 32'hCF000000, 5'd0, 4},
            '{32'hFFFFFFFF, 1'b1, 3'd0, 32'h4F800000, NX,   4},
            '{32'hFFFFFFFF, 1'b1, 3'd1, 32'h4F7FFFFF, NX,   4},
            '{32'h01000001, 1'b0, 3'd0, 32'h4B800000, NX,   11},
            '{32'h01000001, 1'b0, 3'd3, 32'h4B800001, NX,   11},
            '{32'h01000003, 1'b0, 3'd0, 32'h4B800002, NX,   11},
            '{32'hFEFFFFFF, 1'b0, 3'd2, 32'hCB800001, NX,   11},
            '{32'h00000000, 1'b0, 3'd0, 32'h00000000, 5'd0, 2},
            '{32'h00000000, 1'b1, 3'd3, 32'h00000000, 5'd0, 2},
            '{32'h80000000, 1'b1, 3'd1, 32'h4F000000, 5'd0, 4}
        };
        foreach (tbl[i]) begin
            run_conv(tbl[i].v, tbl[i].u, tbl[i].rm, res, fl, lat);
            checks++; if (res !== tbl[i].res) begin errors++; $display("FAIL directed[%0d] result: got %h want %h", i, res, tbl[i].res); end
            checks++; if (fl !== tbl[i].fl) begin errors++; $display("FAIL directed[%0d] flags: got %b want %b", i, fl, tbl[i].fl); end
            checks++; if (lat != tbl[i].lat) begin errors++; $display("FAIL directed[%0d] latency: got %0d want %0d", i, lat, tbl[i].lat); end
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom >> $urandom_range(0, 31);
            2: v = 32'd0 - ($urandom >> $urandom_range(1, 31));
            default: v = (32'd1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 2)) - 32'd1;
        endcase
        return v;
    endfunction

    task automatic test_random();
        logic [31:0] v, res, eres;
        logic [4:0]  fl, efl;
        logic [2:0]  rm;
        logic        u;
        int          lat, elat;
        for (int i = 0; i < 60; i++) begin
            v  = rand_operand();
            u  = 1'($urandom);
            rm = 3'($urandom_range(0, 7));
            ref_model(v, u, rm, eres, efl, elat);
            run_conv(v, u, rm, res, fl, lat);
            checks++; if (res !== eres) begin errors++; $display("FAIL random v=%h u=%b rm=%0d result: got %h want %h", v, u, rm, res, eres); end
            checks++; if (fl !== efl) begin errors++; $display("FAIL random v=%h u=%b rm=%0d flags: got %b want %b", v, u, rm, fl, efl); end
            checks++; if (lat != elat) begin errors++; $display("FAIL random v=%h u=%b rm=%0d latency: got %0d want %0d", v, u, rm, lat, elat); end
        end
    endtask

    task automatic test_busy_ignored();
        int          dones = 0;
        logic [31:0] res = 'x;
        logic [4:0]  fl = 'x;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.rs1_i   = 32'h00000001;
        bus.funct_i = 1'b0;
        bus.rmode_i = 3'd0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) begin
                dones++;
                res = bus.result_o;
                fl  = bus.flags_o;
            end
            bus.start_i = (c == 4 || c == 9 || c == 19 || c == 29);
            bus.rs1_i   = $urandom;
            bus.funct_i = 1'($urandom);
            bus.rmode_i = 3'($urandom);
        end
        bus.start_i = 1'b0;
        checks++; if (dones != 1) begin errors++; $display("FAIL busy done count: got %0d want 1", dones); end
        checks++; if (res !== 32'h3F800000) begin errors++; $display("FAIL busy result: got %h want 3f800000", res); end
        checks++; if (fl !== 5'd0) begin errors++; $display("FAIL busy flags: got %b want 00000", fl); end
    endtask

    task automatic test_reset_mid_op();
        int          dones = 0;
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.rs1_i   = 32'h00000001;
        bus.funct_i = 1'b0;
        bus.rmode_i = 3'd0;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.result_o !== 32'd0) begin errors++; $display("FAIL midreset result: got %h want 00000000", bus.result_o); end
        checks++; if (bus.flags_o !== 5'd0) begin errors++; $display("FAIL midreset flags: got %b want 00000", bus.flags_o); end
        checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL midreset done: got %b want 0", bus.done_o); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (bus.done_o) dones++;
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL midreset stray done: got %0d want 0", dones); end
        run_conv(32'h00000064, 1'b0, 3'd0, res, fl, lat);
        checks++; if (res !== 32'h42C80000) begin errors++; $display("FAIL post-reset result: got %h want 42c80000", res); end
        checks++; if (fl !== 5'd0) begin errors++; $display("FAIL post-reset flags: got %b want 00000", fl); end
        checks++; if (lat != 29) begin errors++; $display("FAIL post-reset latency: got %0d want 29", lat); end
    endtask

    // Second start is driven during the done cycle of the first and must be accepted.
    task automatic test_back_to_back();
        logic [31:0] va, vb, ra, rb, ea, eb;
        logic [4:0]  fa, fb, efa, efb;
        logic [2:0]  rma, rmb;
        int          la, lb, ela, elb;
        for (int i = 0; i < 5; i++) begin
            va = rand_operand(); rma = 3'($urandom_range(0, 4));
            vb = rand_operand(); rmb = 3'($urandom_range(0, 4));
            ref_model(va, 1'b0, rma, ea, efa, ela);
            ref_model(vb, 1'b1, rmb, eb, efb, elb);
            run_conv(va, 1'b0, rma, ra, fa, la);
            run_conv(vb, 1'b1, rmb, rb, fb, lb);
            checks++; if (ra !== ea || fa !== efa) begin errors++; $display("FAIL b2b[%0d] first: got %h/%b want %h/%b", i, ra, fa, ea, efa); end
            checks++; if (rb !== eb || fb !== efb) begin errors++; $display("FAIL b2b[%0d] second: got %h/%b want %h/%b", i, rb, fb, eb, efb); end
            checks++; if (lb != elb) begin errors++; $display("FAIL b2b[%0d] second latency: got %0d want %0d", i, lb, elb); end
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.rs1_i   = 32'd0;
        bus.funct_i = 1'b0;
        bus.rmode_i = 3'd0;
        test_reset();
        test_directed();
        test_random();
        test_busy_ignored();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
